// File: rtl/dmi_jtag_pkg.sv
// -----------------------------------------------------------------------------
// dmi_jtag_pkg
// Shared types and constants for the multi-channel JTAG TAP:
//   tap_state_e  - the 16 IEEE 1149.1 TAP controller states
//   dr_sel_e     - which data register the current instruction selects
//   dtmcs_t      - layout of the 32-bit DTMCS register
//   BYPASS0 / IDCODE - fixed instruction opcodes
//   tap_next()   - TMS-driven next-state function of the TAP controller
// -----------------------------------------------------------------------------
package dmi_jtag_pkg;

    typedef enum logic [3:0] {
        TEST_LOGIC_RESET = 4'd0,
        RUN_TEST_IDLE    = 4'd1,
        SELECT_DR_SCAN   = 4'd2,
        CAPTURE_DR       = 4'd3,
        SHIFT_DR         = 4'd4,
        EXIT1_DR         = 4'd5,
        PAUSE_DR         = 4'd6,
        EXIT2_DR         = 4'd7,
        UPDATE_DR        = 4'd8,
        SELECT_IR_SCAN   = 4'd9,
        CAPTURE_IR       = 4'd10,
        SHIFT_IR         = 4'd11,
        EXIT1_IR         = 4'd12,
        PAUSE_IR         = 4'd13,
        EXIT2_IR         = 4'd14,
        UPDATE_IR        = 4'd15
    } tap_state_e;

    typedef enum logic [1:0] {
        SEL_BYPASS  = 2'd0,
        SEL_IDCODE  = 2'd1,
        SEL_DTMCS   = 2'd2,
        SEL_CHANNEL = 2'd3
    } dr_sel_e;

    typedef struct packed {
        logic [13:0] zero_hi;
        logic        dmihardreset;
        logic        dmireset;
        logic        zero_mid;
        logic [2:0]  idle;
        logic [1:0]  dmistat;
        logic [5:0]  abits;
        logic [3:0]  version;
    } dtmcs_t;

    localparam int unsigned BYPASS0       = 32'd0;
    localparam int unsigned IDCODE        = 32'd1;
    localparam logic [3:0]  DTMCS_VERSION = 4'd1;

    function automatic tap_state_e tap_next(input tap_state_e state, input logic tms);
        tap_state_e nxt;
        case (state)
            TEST_LOGIC_RESET: nxt = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    nxt = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            SELECT_DR_SCAN:   nxt = tms ? SELECT_IR_SCAN   : CAPTURE_DR;
            CAPTURE_DR:       nxt = tms ? EXIT1_DR         : SHIFT_DR;
            SHIFT_DR:         nxt = tms ? EXIT1_DR         : SHIFT_DR;
            EXIT1_DR:         nxt = tms ? UPDATE_DR        : PAUSE_DR;
            PAUSE_DR:         nxt = tms ? EXIT2_DR         : PAUSE_DR;
            EXIT2_DR:         nxt = tms ? UPDATE_DR        : SHIFT_DR;
            UPDATE_DR:        nxt = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            SELECT_IR_SCAN:   nxt = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       nxt = tms ? EXIT1_IR         : SHIFT_IR;
            SHIFT_IR:         nxt = tms ? EXIT1_IR         : SHIFT_IR;
            EXIT1_IR:         nxt = tms ? UPDATE_IR        : PAUSE_IR;
            PAUSE_IR:         nxt = tms ? EXIT2_IR         : PAUSE_IR;
            EXIT2_IR:         nxt = tms ? UPDATE_IR        : SHIFT_IR;
            UPDATE_IR:        nxt = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            default:          nxt = TEST_LOGIC_RESET;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/dmi_jtag_tap_fsm.sv
// -----------------------------------------------------------------------------
// dmi_jtag_tap_fsm
// IEEE 1149.1 TAP controller. State advances on rising tck_i; trst_i is a
// synchronous active-high reset to Test-Logic-Reset.
// The strobe outputs are registered copies of the next-state decode, so each
// one is high for exactly the cycle spent in the corresponding state.
// Ports:
//   tck_i, trst_i, tms_i  - JTAG clock, reset, mode select
//   state_o               - current TAP state
//   test_logic_reset_o    - high while in Test-Logic-Reset
//   capture_dr_o, shift_dr_o, update_dr_o - DR phase strobes
// -----------------------------------------------------------------------------
module dmi_jtag_tap_fsm
    import dmi_jtag_pkg::*;
(
    input  logic       tck_i,
    input  logic       trst_i,
    input  logic       tms_i,
    output tap_state_e state_o,
    output logic       test_logic_reset_o,
    output logic       capture_dr_o,
    output logic       shift_dr_o,
    output logic       update_dr_o
);

    tap_state_e state_r;
    tap_state_e next_state_s;
    logic       tlr_r;
    logic       capture_dr_r;
    logic       shift_dr_r;
    logic       update_dr_r;

    // Next-state decode from TMS.
    always_comb begin
        next_state_s = tap_next(state_r, tms_i);
    end

    // State register with strobes registered alongside it.
    always_ff @(posedge tck_i) begin
        if (trst_i) begin
            state_r      <= TEST_LOGIC_RESET;
            tlr_r        <= 1'b1;
            capture_dr_r <= 1'b0;
            shift_dr_r   <= 1'b0;
            update_dr_r  <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            tlr_r        <= (next_state_s == TEST_LOGIC_RESET);
            capture_dr_r <= (next_state_s == CAPTURE_DR);
            shift_dr_r   <= (next_state_s == SHIFT_DR);
            update_dr_r  <= (next_state_s == UPDATE_DR);
        end
    end

    assign state_o            = state_r;
    assign test_logic_reset_o = tlr_r;
    assign capture_dr_o       = capture_dr_r;
    assign shift_dr_o         = shift_dr_r;
    assign update_dr_o        = update_dr_r;

endmodule

// File: rtl/dmi_jtag_tap_mc.sv
// -----------------------------------------------------------------------------
// dmi_jtag_tap_mc
// Multi-channel JTAG TAP for the debug transport module. Holds the IR, the
// BYPASS / IDCODE / DTMCS registers, instruction decode and the TDO mux.
// External channels own their registers; they receive the shared DR strobes
// and qualify them with their ch_select_o bit.
// Optional feature macro: DMI_JTAG_TAP_IDCODE_EN builds the IDCODE register;
// without it opcode 1 decodes to BYPASS.
// Ports:
//   tck_i, trst_i, tms_i, td_i  - JTAG pins (trst_i synchronous, active-high)
//   td_o, tdo_oe_o              - TDO data/enable, registered on falling tck_i
//   test_logic_reset_o          - high in Test-Logic-Reset
//   capture_dr_o/shift_dr_o/update_dr_o - DR strobes, unqualified by IR
//   ch_select_o, ch_tdi_o, ch_tdo_i     - external channel interface
//   dmi_error_i                 - DMI status captured into DTMCS.dmistat
//   dmi_reset_o, dmi_hardreset_o - one-cycle pulses from a DTMCS write
//   ir_o                        - current instruction
// -----------------------------------------------------------------------------
module dmi_jtag_tap_mc
    import dmi_jtag_pkg::*;
#(
    parameter int unsigned IrLength      = 32'd5,
    parameter logic [31:0] IdcodeValue   = 32'h0000_0001,
    parameter int unsigned DtmcsIr       = 32'h10,
    parameter int unsigned NumChannels   = 32'd2,
    parameter int unsigned ChannelIrBase = 32'h11,
    parameter int unsigned Abits         = 32'd7,
    parameter int unsigned IdleHint      = 32'd1
) (
    input  logic                   tck_i,
    input  logic                   trst_i,
    input  logic                   tms_i,
    input  logic                   td_i,
    output logic                   td_o,
    output logic                   tdo_oe_o,
    output logic                   test_logic_reset_o,
    output logic                   capture_dr_o,
    output logic                   shift_dr_o,
    output logic                   update_dr_o,
    output logic [NumChannels-1:0] ch_select_o,
    output logic                   ch_tdi_o,
    input  logic [NumChannels-1:0] ch_tdo_i,
    input  logic [1:0]             dmi_error_i,
    output logic                   dmi_reset_o,
    output logic                   dmi_hardreset_o,
    output logic [IrLength-1:0]    ir_o
);

    localparam logic [IrLength-1:0] IrBypass0Val = IrLength'(BYPASS0);
    localparam logic [IrLength-1:0] IrIdcodeVal  = IrLength'(IDCODE);
    localparam logic [IrLength-1:0] IrAllOnes    = {IrLength{1'b1}};
    localparam logic [IrLength-1:0] IrDtmcsVal   = IrLength'(DtmcsIr);
    localparam logic [IrLength-1:0] IrCaptureVal = {{(IrLength-2){1'b0}}, 2'b01};

    tap_state_e                 state_s;
    logic                       capture_dr_s;
    logic                       shift_dr_s;
    logic                       update_dr_s;
    logic                       shift_ir_s;
    logic                       enter_tlr_s;
    dr_sel_e                    sel_s;
    dtmcs_t                     dtmcs_capture_s;
    logic                       tdo_mux_s;

    logic [IrLength-1:0]        ir_shift_r;
    logic [IrLength-1:0]        ir_r;
    logic [NumChannels-1:0]     ch_select_r;
    logic                       bypass_r;
    logic [31:0]                dtmcs_r;
`ifdef DMI_JTAG_TAP_IDCODE_EN
    logic [31:0]                idcode_r;
`endif
    logic                       dmi_reset_r;
    logic                       dmi_hardreset_r;
    logic                       td_r;
    logic                       tdo_oe_r;

    // One-hot channel decode of an instruction value.
    function automatic logic [NumChannels-1:0] channel_sel(input logic [IrLength-1:0] ir);
        logic [NumChannels-1:0] sel;
        sel = {NumChannels{1'b0}};
        for (int n = 0; n < int'(NumChannels); n++) begin
            sel[n] = (ir == IrLength'(ChannelIrBase + unsigned'(n)));
        end
        return sel;
    endfunction

    // Instruction to data-register decode; unknown opcodes fall back to BYPASS.
    function automatic dr_sel_e decode_ir(input logic [IrLength-1:0] ir);
        dr_sel_e sel;
        sel = SEL_BYPASS;
        if ((ir == IrBypass0Val) || (ir == IrAllOnes)) begin
            sel = SEL_BYPASS;
`ifdef DMI_JTAG_TAP_IDCODE_EN
        end else if (ir == IrIdcodeVal) begin
            sel = SEL_IDCODE;
`endif
        end else if (ir == IrDtmcsVal) begin
            sel = SEL_DTMCS;
        end else if (channel_sel(ir) != {NumChannels{1'b0}}) begin
            sel = SEL_CHANNEL;
        end else begin
            sel = SEL_BYPASS;
        end
        return sel;
    endfunction

    dmi_jtag_tap_fsm u_fsm (
        .tck_i              (tck_i),
        .trst_i             (trst_i),
        .tms_i              (tms_i),
        .state_o            (state_s),
        .test_logic_reset_o (test_logic_reset_o),
        .capture_dr_o       (capture_dr_s),
        .shift_dr_o         (shift_dr_s),
        .update_dr_o        (update_dr_s)
    );

    // IR-side state decodes; the IR is reset on the edge that enters TLR so
    // ir_o already reads IDCODE in the first TLR cycle.
    always_comb begin
        shift_ir_s  = (state_s == SHIFT_IR);
        enter_tlr_s = (tap_next(state_s, tms_i) == TEST_LOGIC_RESET);
        sel_s       = decode_ir(ir_r);
    end

    // DTMCS capture image.
    always_comb begin
        dtmcs_capture_s              = '{default: 1'b0};
        dtmcs_capture_s.idle         = 3'(IdleHint);
        dtmcs_capture_s.dmistat      = dmi_error_i;
        dtmcs_capture_s.abits        = 6'(Abits);
        dtmcs_capture_s.version      = DTMCS_VERSION;
    end

    // Instruction register: capture, shift, update.
    always_ff @(posedge tck_i) begin
        if (trst_i || enter_tlr_s) begin
            ir_shift_r  <= {IrLength{1'b0}};
            ir_r        <= IrIdcodeVal;
            ch_select_r <= {NumChannels{1'b0}};
        end else if (state_s == CAPTURE_IR) begin
            ir_shift_r  <= IrCaptureVal;
        end else if (shift_ir_s) begin
            ir_shift_r  <= {td_i, ir_shift_r[IrLength-1:1]};
        end else if (state_s == UPDATE_IR) begin
            ir_r        <= ir_shift_r;
            ch_select_r <= channel_sel(ir_shift_r);
        end else begin
            ir_shift_r  <= ir_shift_r;
        end
    end

    // Internal data registers, only the selected one captures or shifts.
    always_ff @(posedge tck_i) begin
        if (trst_i) begin
            bypass_r <= 1'b0;
            dtmcs_r  <= 32'h0;
`ifdef DMI_JTAG_TAP_IDCODE_EN
            idcode_r <= IdcodeValue;
`endif
        end else if (capture_dr_s) begin
            case (sel_s)
                SEL_BYPASS: bypass_r <= 1'b0;
`ifdef DMI_JTAG_TAP_IDCODE_EN
                SEL_IDCODE: idcode_r <= IdcodeValue;
`endif
                SEL_DTMCS:  dtmcs_r  <= dtmcs_capture_s;
                default:    bypass_r <= bypass_r;
            endcase
        end else if (shift_dr_s) begin
            case (sel_s)
                SEL_BYPASS: bypass_r <= td_i;
`ifdef DMI_JTAG_TAP_IDCODE_EN
                SEL_IDCODE: idcode_r <= {td_i, idcode_r[31:1]};
`endif
                SEL_DTMCS:  dtmcs_r  <= {td_i, dtmcs_r[31:1]};
                default:    bypass_r <= bypass_r;
            endcase
        end else begin
            bypass_r <= bypass_r;
        end
    end

    // DMI reset pulses: high only in the cycle after UpdateDr of DTMCS.
    always_ff @(posedge tck_i) begin
        if (trst_i) begin
            dmi_reset_r     <= 1'b0;
            dmi_hardreset_r <= 1'b0;
        end else if (update_dr_s && (sel_s == SEL_DTMCS)) begin
            dmi_reset_r     <= dtmcs_r[16];
            dmi_hardreset_r <= dtmcs_r[17];
        end else begin
            dmi_reset_r     <= 1'b0;
            dmi_hardreset_r <= 1'b0;
        end
    end

    // TDO source select; channels are ORed through their one-hot select.
    always_comb begin
        tdo_mux_s = 1'b0;
        if (shift_ir_s) begin
            tdo_mux_s = ir_shift_r[0];
        end else begin
            case (sel_s)
                SEL_BYPASS:  tdo_mux_s = bypass_r;
`ifdef DMI_JTAG_TAP_IDCODE_EN
                SEL_IDCODE:  tdo_mux_s = idcode_r[0];
`endif
                SEL_DTMCS:   tdo_mux_s = dtmcs_r[0];
                SEL_CHANNEL: tdo_mux_s = |(ch_tdo_i & ch_select_r);
                default:     tdo_mux_s = 1'b0;
            endcase
        end
    end

    // TDO and its enable launch on the falling edge; data is held low when idle.
    always_ff @(negedge tck_i) begin
        if (trst_i) begin
            td_r     <= 1'b0;
            tdo_oe_r <= 1'b0;
        end else begin
            tdo_oe_r <= shift_ir_s | shift_dr_s;
            td_r     <= (shift_ir_s | shift_dr_s) ? tdo_mux_s : 1'b0;
        end
    end

    assign td_o            = td_r;
    assign tdo_oe_o        = tdo_oe_r;
    assign capture_dr_o    = capture_dr_s;
    assign shift_dr_o      = shift_dr_s;
    assign update_dr_o     = update_dr_s;
    assign ch_select_o     = ch_select_r;
    assign ch_tdi_o        = td_i;
    assign dmi_reset_o     = dmi_reset_r;
    assign dmi_hardreset_o = dmi_hardreset_r;
    assign ir_o            = ir_r;

endmodule

// File: tb/tb_dmi_jtag_tap_mc.sv
// -----------------------------------------------------------------------------
// tb_dmi_jtag_tap_mc
// Directed bench for dmi_jtag_tap_mc: reset values, IDCODE/BYPASS scans, IR
// capture, TLR via TMS, channel select and TDO forwarding, DTMCS read/write
// pulses, and reset in the middle of a shift. Honours DMI_JTAG_TAP_IDCODE_EN.
// -----------------------------------------------------------------------------
module tb_dmi_jtag_tap_mc;

    localparam int IrLen = 5;

    logic       tck = 1'b0;
    logic       trst_i = 1'b1;
    logic       tms_i = 1'b1;
    logic       td_i = 1'b0;
    logic       td_o;
    logic       tdo_oe_o;
    logic       test_logic_reset_o;
    logic       capture_dr_o;
    logic       shift_dr_o;
    logic       update_dr_o;
    logic [1:0] ch_select_o;
    logic       ch_tdi_o;
    logic [1:0] ch_tdo_i = 2'b00;
    logic [1:0] dmi_error_i = 2'b00;
    logic       dmi_reset_o;
    logic       dmi_hardreset_o;
    logic [4:0] ir_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] dout;
    logic        oe_ok;

    dmi_jtag_tap_mc #(
        .IrLength      (32'd5),
        .IdcodeValue   (32'h0000_0001),
        .DtmcsIr       (32'h10),
        .NumChannels   (32'd2),
        .ChannelIrBase (32'h11),
        .Abits         (32'd7),
        .IdleHint      (32'd1)
    ) dut (
        .tck_i              (tck),
        .trst_i             (trst_i),
        .tms_i              (tms_i),
        .td_i               (td_i),
        .td_o               (td_o),
        .tdo_oe_o           (tdo_oe_o),
        .test_logic_reset_o (test_logic_reset_o),
        .capture_dr_o       (capture_dr_o),
        .shift_dr_o         (shift_dr_o),
        .update_dr_o        (update_dr_o),
        .ch_select_o        (ch_select_o),
        .ch_tdi_o           (ch_tdi_o),
        .ch_tdo_i           (ch_tdo_i),
        .dmi_error_i        (dmi_error_i),
        .dmi_reset_o        (dmi_reset_o),
        .dmi_hardreset_o    (dmi_hardreset_o),
        .ir_o               (ir_o)
    );

    // Free-running JTAG clock.
    always #5 tck = ~tck;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drive TMS/TDI, take one rising edge, and settle just past the falling edge.
    task automatic clk(input logic tms, input logic tdi);
        tms_i = tms;
        td_i  = tdi;
        @(posedge tck);
        @(negedge tck);
        #1;
    endtask

    // From Run-Test/Idle: IR scan of val, ends back in Run-Test/Idle.
    task automatic scan_ir(input logic [4:0] val, output logic [31:0] cap);
        cap = 32'h0;
        clk(1'b1, 1'b0);
        clk(1'b1, 1'b0);
        clk(1'b0, 1'b0);
        clk(1'b0, 1'b0);
        for (int k = 0; k < IrLen; k++) begin
            cap[k] = td_o;
            clk(k == IrLen - 1, val[k]);
        end
        clk(1'b1, 1'b0);
        clk(1'b0, 1'b0);
    endtask

    // From Run-Test/Idle: DR scan of n bits, ends in Exit1-DR.
    // Channel outputs present chd bit k on ch_tdo_i[1] and its inverse on [0].
    task automatic scan_dr(input int n, input logic [31:0] tdi, input logic [31:0] chd,
                           output logic [31:0] out, output logic oe_good);
        out     = 32'h0;
        oe_good = 1'b1;
        ch_tdo_i = {chd[0], ~chd[0]};
        clk(1'b1, 1'b0);
        clk(1'b0, 1'b0);
        check("capture_dr strobe", {31'h0, capture_dr_o}, 32'h1);
        if (tdo_oe_o !== 1'b0) oe_good = 1'b0;
        clk(1'b0, 1'b0);
        for (int k = 0; k < n; k++) begin
            out[k] = td_o;
            if (tdo_oe_o !== 1'b1) oe_good = 1'b0;
            if (k + 1 < n) ch_tdo_i = {chd[k+1], ~chd[k+1]};
            clk(k == n - 1, tdi[k]);
        end
        if (tdo_oe_o !== 1'b0) oe_good = 1'b0;
    endtask

    initial begin
        // Reset values.
        trst_i = 1'b1;
        clk(1'b0, 1'b0);
        clk(1'b0, 1'b0);
        check("rst tlr", {31'h0, test_logic_reset_o}, 32'h1);
        check("rst ir", {27'h0, ir_o}, 32'h1);
        check("rst ch_select", {30'h0, ch_select_o}, 32'h0);
        check("rst strobes", {29'h0, capture_dr_o, shift_dr_o, update_dr_o}, 32'h0);
        check("rst tdo", {30'h0, td_o, tdo_oe_o}, 32'h0);
        check("rst pulses", {30'h0, dmi_reset_o, dmi_hardreset_o}, 32'h0);
        trst_i = 1'b0;
        clk(1'b0, 1'b0);
        check("rti tlr low", {31'h0, test_logic_reset_o}, 32'h0);

        // Post-reset 32-bit DR scan.
        scan_dr(32, 32'h0000_0003, 32'h0, dout, oe_ok);
`ifdef DMI_JTAG_TAP_IDCODE_EN
        check("idcode scan", dout, 32'h0000_0001);
`else
        check("reset bypass scan", dout, 32'h0000_0006);
`endif
        check("oe only in shift", {31'h0, oe_ok}, 32'h1);
        clk(1'b1, 1'b0);
        check("update_dr strobe", {31'h0, update_dr_o}, 32'h1);
        clk(1'b0, 1'b0);

        // IR 0x1F (BYPASS): captured IR value and one-bit delay.
        scan_ir(5'h1F, dout);
        check("ir capture", dout, 32'h0000_0001);
        check("ir 1f", {27'h0, ir_o}, 32'h1F);
        scan_dr(8, 32'h0000_00A5, 32'h0, dout, oe_ok);
        check("bypass a5", dout, 32'h0000_004A);
        clk(1'b1, 1'b0);
        clk(1'b0, 1'b0);

        // Five TMS=1 clocks from ShiftDr reach TLR with IR back to IDCODE.
        clk(1'b1, 1'b0);
        clk(1'b0, 1'b0);
        clk(1'b0, 1'b0);
        check("shift_dr strobe", {31'h0, shift_dr_o}, 32'h1);
        for (int k = 0; k < 5; k++) clk(1'b1, 1'b0);
        check("tms tlr", {31'h0, test_logic_reset_o}, 32'h1);
        check("tms tlr ir", {27'h0, ir_o}, 32'h1);
        clk(1'b0, 1'b0);

        // Channel 1 selected; TDO forwards ch_tdo_i[1].
        scan_ir(5'h12, dout);
        check("ch1 select", {30'h0, ch_select_o}, 32'h2);
        td_i = 1'b1;
        #1;
        check("ch_tdi", {31'h0, ch_tdi_o}, 32'h1);
        scan_dr(8, 32'h0, 32'h0000_0096, dout, oe_ok);
        check("ch1 tdo", dout, 32'h0000_0096);
        clk(1'b1, 1'b0);
        clk(1'b0, 1'b0);

        // Unassigned opcode falls back to BYPASS.
        scan_ir(5'h15, dout);
        check("0x15 no channel", {30'h0, ch_select_o}, 32'h0);
        scan_dr(4, 32'h0000_000F, 32'h0, dout, oe_ok);
        check("0x15 bypass", dout, 32'h0000_000E);
        clk(1'b1, 1'b0);
        clk(1'b0, 1'b0);

        // DTMCS read.
        dmi_error_i = 2'd2;
        scan_ir(5'h10, dout);
        check("dtmcs ir", {27'h0, ir_o}, 32'h10);
        scan_dr(32, 32'h0, 32'h0, dout, oe_ok);
        check("dtmcs read", dout, 32'h0000_1871);
        clk(1'b1, 1'b0);
        clk(1'b0, 1'b0);
        check("no pulse on zero write", {30'h0, dmi_reset_o, dmi_hardreset_o}, 32'h0);

        // DTMCS write with both reset bits.
        scan_dr(32, 32'h0003_0000, 32'h0, dout, oe_ok);
        clk(1'b1, 1'b0);
        check("pulses in updatedr", {30'h0, dmi_reset_o, dmi_hardreset_o}, 32'h0);
        clk(1'b0, 1'b0);
        check("both pulses", {30'h0, dmi_reset_o, dmi_hardreset_o}, 32'h3);
        clk(1'b0, 1'b0);
        check("pulses end", {30'h0, dmi_reset_o, dmi_hardreset_o}, 32'h0);

        // DTMCS write with dmireset only.
        scan_dr(32, 32'h0001_0000, 32'h0, dout, oe_ok);
        clk(1'b1, 1'b0);
        clk(1'b0, 1'b0);
        check("dmireset only", {30'h0, dmi_reset_o, dmi_hardreset_o}, 32'h2);
        clk(1'b0, 1'b0);

        // Reset in the middle of a DTMCS write shift.
        clk(1'b1, 1'b0);
        clk(1'b0, 1'b0);
        clk(1'b0, 1'b0);
        for (int k = 0; k < 20; k++) clk(1'b0, (k == 16) || (k == 17));
        trst_i = 1'b1;
        clk(1'b1, 1'b0);
        check("mid-shift rst tlr", {31'h0, test_logic_reset_o}, 32'h1);
        check("mid-shift rst strobes", {29'h0, capture_dr_o, shift_dr_o, update_dr_o}, 32'h0);
        check("mid-shift rst tdo", {30'h0, td_o, tdo_oe_o}, 32'h0);
        check("mid-shift rst ir", {27'h0, ir_o}, 32'h1);
        check("mid-shift rst pulses", {30'h0, dmi_reset_o, dmi_hardreset_o}, 32'h0);
        trst_i = 1'b0;
        clk(1'b1, 1'b0);
        check("after rst pulses", {30'h0, dmi_reset_o, dmi_hardreset_o}, 32'h0);
        check("after rst update", {31'h0, update_dr_o}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
